// File: rtl/ula_arbiter_if.sv
// Requester-side bus of the ULA arbiter: request/grant, per-requester operands and the
// shared result handshake. Requesters use the master modport, the arbiter uses slave.
interface ula_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4
);
    logic [1:0]        _req;
    logic [DATA_W-1:0] _op1_0;
    logic [DATA_W-1:0] _op1_1;
    logic [DATA_W-1:0] _op2_0;
    logic [DATA_W-1:0] _op2_1;
    logic [SEL_W-1:0]  _sel_0;
    logic [SEL_W-1:0]  _sel_1;
    logic [1:0]        _gnt;
    logic [1:0]        _resp_valid;
    logic [1:0]        _resp_ready;
    logic [DATA_W-1:0] _resp_data;

    modport master (
        output _req, _op1_0, _op1_1, _op2_0, _op2_1, _sel_0, _sel_1, _resp_ready,
        input  _gnt, _resp_valid, _resp_data
    );

    modport slave (
        input  _req, _op1_0, _op1_1, _op2_0, _op2_1, _sel_0, _sel_1, _resp_ready,
        output _gnt, _resp_valid, _resp_data
    );
endinterface

// File: rtl/ula_arbiter.sv
// Shares one combinational ULA between two requesters: arbitrate, hold operands for ULA_LAT
// cycles, capture the result and hand it back. Define ULA_ARB_FIXED_PRIO_EN for fixed priority.
module ula_arbiter #(
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 4,
    parameter int ULA_LAT = 1
) (
    input  logic              _clk,
    input  logic              _rst_n,
    ula_arbiter_if.slave      bus,
    output logic [DATA_W-1:0] _ula_op1,
    output logic [DATA_W-1:0] _ula_op2,
    output logic [SEL_W-1:0]  _ula_opcao,
    input  logic [DATA_W-1:0] _ula_result,
    output logic              _busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]        state;
    logic              owner;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] resp_data_q;
    logic              any_req;
    logic              win_idx;

`ifndef ULA_ARB_FIXED_PRIO_EN
    logic              last_gnt;
`endif

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        any_req = |bus._req;
        win_idx = 1'b0;
        case (bus._req)
            2'b10:   win_idx = 1'b1;
`ifdef ULA_ARB_FIXED_PRIO_EN
            2'b11:   win_idx = 1'b0;
`else
            2'b11:   win_idx = ~last_gnt;
`endif
            default: win_idx = 1'b0;
        endcase
    end

    // Grant is a same-cycle pulse; masked by reset so every output is 0 while reset is held.
    assign bus._gnt        = (_rst_n && state == IDLE && any_req) ? (2'b01 << win_idx) : 2'b00;
    assign bus._resp_valid = (state == RESP) ? (2'b01 << owner) : 2'b00;
    assign bus._resp_data  = resp_data_q;
    assign _busy           = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments only; all registers here are small
    // flops, so each gets an explicit async reset value.
    always_ff @(posedge _clk or negedge _rst_n) begin
        if (!_rst_n) begin
            state       <= IDLE;
            owner       <= 1'b0;
            cnt         <= '0;
            resp_data_q <= '0;
            _ula_op1    <= '0;
            _ula_op2    <= '0;
            _ula_opcao  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        _ula_op1   <= win_idx ? bus._op1_1 : bus._op1_0;
                        _ula_op2   <= win_idx ? bus._op2_1 : bus._op2_0;
                        _ula_opcao <= win_idx ? bus._sel_1 : bus._sel_0;
                        owner      <= win_idx;
                        cnt        <= 4'(ULA_LAT - 1);
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cnt == 4'd0) begin
                        resp_data_q <= _ula_result;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus._resp_ready[owner]) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef ULA_ARB_FIXED_PRIO_EN
    // Pointer starts at 1 so requester 0 wins the first tie after reset.
    always_ff @(posedge _clk or negedge _rst_n) begin
        if (!_rst_n)             last_gnt <= 1'b1;
        else if (bus._gnt != 0)  last_gnt <= win_idx;
    end
`endif

endmodule

// File: tb/tb_ula_arbiter.sv
// Directed bench for ula_arbiter: one instance with ULA_LAT=1 and one with ULA_LAT=3,
// each driving an adder stub as its ULA.
module tb_ula_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    ula_arbiter_if #(.DATA_W(32), .SEL_W(4)) if1 ();
    ula_arbiter_if #(.DATA_W(32), .SEL_W(4)) if3 ();

    logic [31:0] ula_op1_1, ula_op2_1, ula_res_1;
    logic [31:0] ula_op1_3, ula_op2_3, ula_res_3;
    logic [3:0]  ula_opcao_1, ula_opcao_3;
    logic        busy_1, busy_3;

    assign ula_res_1 = ula_op1_1 + ula_op2_1;
    assign ula_res_3 = ula_op1_3 + ula_op2_3;

    ula_arbiter #(.DATA_W(32), .SEL_W(4), .ULA_LAT(1)) dut1 (
        ._clk(clk), ._rst_n(rst_n), .bus(if1),
        ._ula_op1(ula_op1_1), ._ula_op2(ula_op2_1), ._ula_opcao(ula_opcao_1),
        ._ula_result(ula_res_1), ._busy(busy_1)
    );

    ula_arbiter #(.DATA_W(32), .SEL_W(4), .ULA_LAT(3)) dut3 (
        ._clk(clk), ._rst_n(rst_n), .bus(if3),
        ._ula_op1(ula_op1_3), ._ula_op2(ula_op2_3), ._ula_opcao(ula_opcao_3),
        ._ula_result(ula_res_3), ._busy(busy_3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0]  exp_gnt;
    logic [31:0] exp_data;

    initial begin
        if1._req = 2'b00; if1._resp_ready = 2'b00;
        if1._op1_0 = '0; if1._op2_0 = '0; if1._sel_0 = '0;
        if1._op1_1 = '0; if1._op2_1 = '0; if1._sel_1 = '0;
        if3._req = 2'b00; if3._resp_ready = 2'b00;
        if3._op1_0 = '0; if3._op2_0 = '0; if3._sel_0 = '0;
        if3._op1_1 = '0; if3._op2_1 = '0; if3._sel_1 = '0;

        // Reset release with no requests
        tick(); tick();
        rst_n = 1'b1;
        #1;
        check("rst_gnt",   32'(if1._gnt), 32'h0);
        check("rst_valid", 32'(if1._resp_valid), 32'h0);
        check("rst_busy",  32'(busy_1), 32'h0);
        check("rst_op1",   ula_op1_1, 32'h0);
        check("rst_op2",   ula_op2_1, 32'h0);
        check("rst_opcao", 32'(ula_opcao_1), 32'h0);
        check("rst_data",  if1._resp_data, 32'h0);

        // Both requesting with ready tied high: round-robin (or fixed) grant sequence
        tick();
        if1._req = 2'b11; if1._resp_ready = 2'b11;
        if1._op1_0 = 32'd1; if1._op2_0 = 32'd1;
        if1._op1_1 = 32'd2; if1._op2_1 = 32'd2;
        for (int i = 0; i < 4; i++) begin
`ifdef ULA_ARB_FIXED_PRIO_EN
            exp_gnt = 2'b01;
`else
            exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
            exp_data = (exp_gnt == 2'b01) ? 32'd2 : 32'd4;
            #1;
            check($sformatf("rr_gnt%0d", i), 32'(if1._gnt), 32'(exp_gnt));
            tick(); tick();
            check($sformatf("rr_valid%0d", i), 32'(if1._resp_valid), 32'(exp_gnt));
            check($sformatf("rr_data%0d", i), if1._resp_data, exp_data);
            tick();
        end
        if1._req = 2'b00; if1._resp_ready = 2'b00;

        // Single requester 0: 0x0A + 0x02, op select 1
        tick();
        if1._req = 2'b01; if1._op1_0 = 32'h0A; if1._op2_0 = 32'h02; if1._sel_0 = 4'h1;
        #1;
        check("s0_gnt", 32'(if1._gnt), 32'h1);
        tick();
        if1._req = 2'b00;
        #1;
        check("s0_opcao", 32'(ula_opcao_1), 32'h1);
        check("s0_op1",   ula_op1_1, 32'h0A);
        check("s0_busy",  32'(busy_1), 32'h1);
        check("s0_novalid", 32'(if1._resp_valid), 32'h0);
        tick();
        check("s0_valid", 32'(if1._resp_valid), 32'h1);
        check("s0_data",  if1._resp_data, 32'h0C);
        if1._resp_ready = 2'b01;
        tick();
        if1._resp_ready = 2'b00;
        check("s0_idle_busy",  32'(busy_1), 32'h0);
        check("s0_idle_valid", 32'(if1._resp_valid), 32'h0);

        // Owner 1 result held under backpressure; non-owner ready and new requests ignored
        if1._req = 2'b10; if1._op1_1 = 32'hF6; if1._op2_1 = 32'h0A; if1._sel_1 = 4'h2;
        #1;
        check("bp_gnt", 32'(if1._gnt), 32'h2);
        tick();
        if1._req = 2'b01; if1._op1_0 = 32'h3; if1._op2_0 = 32'h4;
        tick();
        if1._resp_ready = 2'b01;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_valid%0d", i), 32'(if1._resp_valid), 32'h2);
            check($sformatf("bp_data%0d", i),  if1._resp_data, 32'h100);
            check($sformatf("bp_nogt%0d", i),  32'(if1._gnt), 32'h0);
            tick();
        end
        if1._resp_ready = 2'b10;
        #1;
        check("bp_nogt_acc", 32'(if1._gnt), 32'h0);
        tick();
        check("bp_after_gnt", 32'(if1._gnt), 32'h1);
        tick();
        if1._req = 2'b00; if1._resp_ready = 2'b00;
        tick();
        check("bp_after_data", if1._resp_data, 32'h7);
        if1._resp_ready = 2'b01;
        tick();
        if1._resp_ready = 2'b00;
        check("bp_after_idle", 32'(busy_1), 32'h0);

        // ULA_LAT=3: valid four cycles after grant, operand changes after grant ignored
        if3._req = 2'b01; if3._op1_0 = 32'h5; if3._op2_0 = 32'h7;
        #1;
        check("l3_gnt", 32'(if3._gnt), 32'h1);
        tick();
        if3._req = 2'b00; if3._op1_0 = 32'hFF;
        check("l3_v1", 32'(if3._resp_valid), 32'h0);
        tick();
        check("l3_v2", 32'(if3._resp_valid), 32'h0);
        tick();
        check("l3_v3", 32'(if3._resp_valid), 32'h0);
        check("l3_busy3", 32'(busy_3), 32'h1);
        tick();
        check("l3_v4",   32'(if3._resp_valid), 32'h1);
        check("l3_data", if3._resp_data, 32'h0C);
        if3._resp_ready = 2'b01;
        tick();
        if3._resp_ready = 2'b00;
        check("l3_idle", 32'(busy_3), 32'h0);

        // Async reset during ISSUE drops the operation; first tie afterwards grants 0
        if3._req = 2'b11; if3._op1_1 = 32'h11; if3._op2_1 = 32'h22;
        #1;
`ifdef ULA_ARB_FIXED_PRIO_EN
        check("ar_gnt", 32'(if3._gnt), 32'h1);
`else
        check("ar_gnt", 32'(if3._gnt), 32'h2);
`endif
        tick();
        if3._req = 2'b00;
        check("ar_busy_pre", 32'(busy_3), 32'h1);
        #2;
        rst_n = 1'b0;
        if3._req = 2'b11;
        #1;
        check("ar_busy",  32'(busy_3), 32'h0);
        check("ar_op1",   ula_op1_3, 32'h0);
        check("ar_data",  if3._resp_data, 32'h0);
        check("ar_gnt_in_rst", 32'(if3._gnt), 32'h0);
        if3._req = 2'b00;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("ar_novalid%0d", i), 32'(if3._resp_valid), 32'h0);
        end
        if3._req = 2'b11;
        #1;
        check("ar_tie_gnt", 32'(if3._gnt), 32'h1);
        tick();
        if3._req = 2'b00;
        tick(); tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
